// File: rtl/mem_avalon_pkg.sv
// Shared defaults and types for the Avalon-MM memory master.
package mem_avalon_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BE_W       = DATA_W_DEF / 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W-1:0]       be;
  } mem_req_t;

  // Pointer width that stays legal for a depth of 1.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Read-response FIFO: synchronous active-low reset, combinational head, count output.
module mem_resp_fifo import mem_avalon_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CntW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_pop  = pop & ~empty;
  // A push alongside a pop is safe when full: the slot being freed is the one written.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrW'(DEPTH - 1)) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(DEPTH - 1)) ? '0 : r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_avalon_master.sv
// CPU-to-Avalon-MM master with credit-based read response buffering.
// Optional MEM_AVALON_MASTER_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_avalon_master import mem_avalon_pkg::*; #(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
`ifdef MEM_AVALON_MASTER_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  logic                    r_cs;
  logic                    r_wr;
  logic [ADDR_W-1:0]       r_addr;
  logic [BeW-1:0]          r_be;
  logic [DATA_W-1:0]       r_wdata;
  logic [READ_LATENCY-1:0] r_inflight;

  logic                    w_accept;
  logic                    w_issue_rd;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CntW-1:0]         w_fifo_count;
  logic [DATA_W-1:0]       w_fifo_rdata;
  int unsigned             w_credits_used;

  assign w_issue_rd = r_cs & ~r_wr;

  // Every read already committed (issuing, in flight, or buffered) holds one FIFO slot.
  always_comb begin
    w_credits_used = 32'(w_fifo_count) + 32'(w_issue_rd);
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_credits_used = w_credits_used + 32'(r_inflight[i]);
    end
  end

  assign req_ready = reset_n & (w_credits_used < RESP_DEPTH);
  assign w_accept  = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_cs <= w_accept;
      r_wr <= w_accept & req_write;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_be    <= req_be;
        r_wdata <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inflight <= '0;
    end else begin
      r_inflight[0] <= w_issue_rd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
    end
  end

  assign w_push = r_inflight[READ_LATENCY-1];
  assign w_pop  = resp_valid & resp_ready;

  mem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (avm_readdata),
    .pop     (w_pop),
    .rdata   (w_fifo_rdata),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // The credit check makes this impossible; firing means the accounting is broken.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(w_push && w_fifo_full))
        else $error("mem_avalon_master: response pushed into full FIFO");
    end
  end

  assign resp_valid     = reset_n & ~w_fifo_empty;
  assign resp_rdata     = reset_n ? w_fifo_rdata : '0;
  assign avm_chipselect = reset_n & r_cs;
  assign avm_write      = reset_n & r_wr;
  assign avm_address    = reset_n ? r_addr : '0;
  assign avm_byteenable = reset_n ? r_be : '0;
  assign avm_writedata  = reset_n ? r_wdata : '0;
  assign avm_clken      = reset_n;

`ifdef MEM_AVALON_MASTER_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_accept) begin
      if (req_write) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_avalon_master.sv
// Directed bench for mem_avalon_master with a latency-1 byte-enabled memory model.
module tb_mem_avalon_master;
  import mem_avalon_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic [15:0] avm_address;
  logic [1:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_clken;
`ifdef MEM_AVALON_MASTER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_avalon_master #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .READ_LATENCY (1),
    .RESP_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken)
`ifdef MEM_AVALON_MASTER_STATS_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: contents preset to A000+addr during reset, read data one cycle later.
  logic [15:0] mem [65536];
  logic [15:0] rd_q;
  assign avm_readdata = rd_q;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) + 16'hA000;
    end else if (avm_clken && avm_chipselect) begin
      if (avm_write) begin
        if (avm_byteenable[0]) mem[avm_address][7:0]  <= avm_writedata[7:0];
        if (avm_byteenable[1]) mem[avm_address][15:8] <= avm_writedata[15:8];
      end else begin
        rd_q <= mem[avm_address];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic issue(input mem_req_t r);
    chk("issue_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    req_be    = r.be;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int k;
    int nresp;
    int cs_cnt;
    int first;
    int last;
    int stall;
    int seen;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'd0);
    chk("rst_wdata", 32'(avm_writedata), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_clken", 32'(avm_clken), 32'd0);

    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_clken", 32'(avm_clken), 32'd1);
    tick();

    // Single write then read-after-write
    issue('{write: 1'b1, addr: 16'h0010, wdata: 16'hBEEF, be: 2'b11});
    chk("w1_cs", 32'(avm_chipselect), 32'd1);
    chk("w1_write", 32'(avm_write), 32'd1);
    chk("w1_addr", 32'(avm_address), 32'h10);
    chk("w1_wdata", 32'(avm_writedata), 32'hBEEF);
    chk("w1_be", 32'(avm_byteenable), 32'h3);
    issue('{write: 1'b0, addr: 16'h0010, wdata: 16'h0000, be: 2'b11});
    chk("r1_cs", 32'(avm_chipselect), 32'd1);
    chk("r1_write", 32'(avm_write), 32'd0);
    chk("r1_addr", 32'(avm_address), 32'h10);
    tick();
    chk("idle_cs", 32'(avm_chipselect), 32'd0);
    chk("idle_write", 32'(avm_write), 32'd0);
    chk("idle_addr_hold", 32'(avm_address), 32'h10);
    chk("r1_not_yet", 32'(resp_valid), 32'd0);
    tick();
    chk("r1_valid", 32'(resp_valid), 32'd1);
    chk("r1_data", 32'(resp_rdata), 32'hBEEF);
    tick();
    chk("r1_popped", 32'(resp_valid), 32'd0);

    // Byte-enabled write merge
    issue('{write: 1'b1, addr: 16'h0020, wdata: 16'h1234, be: 2'b11});
    issue('{write: 1'b1, addr: 16'h0020, wdata: 16'hAB00, be: 2'b10});
    chk("bw_be", 32'(avm_byteenable), 32'h2);
    chk("bw_wdata", 32'(avm_writedata), 32'hAB00);
    issue('{write: 1'b0, addr: 16'h0020, wdata: 16'h0000, be: 2'b11});
    tick();
    tick();
    chk("bw_valid", 32'(resp_valid), 32'd1);
    chk("bw_data", 32'(resp_rdata), 32'hAB34);
    tick();

    // Backpressure: only RESP_DEPTH reads get credits
    resp_ready = 1'b0;
    req_write  = 1'b0;
    req_be     = 2'b11;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 16'h0030 + 16'(acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data", 32'(resp_rdata), 32'hA030 + 32'(j));
      tick();
    end
    chk("bp_drained", 32'(resp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);

    // Streaming: 16 back-to-back reads
    k = 0;
    nresp = 0;
    cs_cnt = 0;
    first = -1;
    last = -1;
    stall = 0;
    for (int c = 0; c < 24; c++) begin
      if (avm_chipselect) begin
        cs_cnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (resp_valid) begin
        chk("st_data", 32'(resp_rdata), 32'hA040 + 32'(nresp));
        nresp++;
      end
      if (k < 16) begin
        req_valid = 1'b1;
        req_addr  = 16'h0040 + 16'(k);
        if (req_ready) k++;
        else stall++;
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("st_cs_count", 32'(cs_cnt), 32'd16);
    chk("st_cs_span", 32'(last - first + 1), 32'd16);
    chk("st_resp_count", 32'(nresp), 32'd16);
    chk("st_stalls", 32'(stall), 32'd0);

    // Reset while a read is in flight
    issue('{write: 1'b0, addr: 16'h0050, wdata: 16'h0000, be: 2'b11});
    tick();
    reset_n = 1'b0;
    #1;
    chk("mr_ready_low", 32'(req_ready), 32'd0);
    chk("mr_clken_low", 32'(avm_clken), 32'd0);
    chk("mr_valid_low", 32'(resp_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mr_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen++;
      tick();
    end
    chk("mr_no_late_resp", 32'(seen), 32'd0);
    chk("mr_ready_after", 32'(req_ready), 32'd1);

`ifdef MEM_AVALON_MASTER_STATS_EN
    chk("stats_rd_zero", 32'(rd_count), 32'd0);
    chk("stats_wr_zero", 32'(wr_count), 32'd0);
    issue('{write: 1'b0, addr: 16'h0060, wdata: 16'h0000, be: 2'b11});
    issue('{write: 1'b1, addr: 16'h0061, wdata: 16'h1111, be: 2'b11});
    issue('{write: 1'b0, addr: 16'h0062, wdata: 16'h0000, be: 2'b11});
    issue('{write: 1'b1, addr: 16'h0063, wdata: 16'h2222, be: 2'b11});
    issue('{write: 1'b0, addr: 16'h0064, wdata: 16'h0000, be: 2'b11});
    tick();
    tick();
    tick();
    chk("stats_rd", 32'(rd_count), 32'd3);
    chk("stats_wr", 32'(wr_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
